// File: rtl/sprite_pkg.sv
// sprite_pkg: shared FSM states, direction codes and screen constants for the sprite mover.
package sprite_pkg;
  typedef enum logic [2:0] {INIT_DRAW, IDLE, ERASE, UPDATE, DRAW} state_t;
  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  function automatic logic is_scan(input state_t s);
    return s == INIT_DRAW || s == ERASE || s == DRAW;
  endfunction
endpackage

// File: rtl/box_scanner.sv
// box_scanner: raster walk over a SIZE x SIZE box, cx fastest, done on the last pixel.
module box_scanner #(
  parameter int SIZE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  output logic [2:0] cx,
  output logic [2:0] cy,
  output logic       done
);
  localparam logic [2:0] LAST = 3'(SIZE - 1);
  assign done = step && cx == LAST && cy == LAST;
  always_ff @(posedge clk) begin
    if (reset || start) begin
      cx <= '0;
      cy <= '0;
    end else if (step) begin
      cx <= cx == LAST ? 3'd0 : cx + 3'd1;
      if (cx == LAST) cy <= cy == LAST ? 3'd0 : cy + 3'd1;
    end
  end
endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: per game tick, erase the sprite box, step it one pixel with wall clamping, redraw it.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int         SIZE          = 4,
  parameter int         X_MAX         = SCREEN_W,
  parameter int         Y_MAX         = SCREEN_H,
  parameter int         X_START       = 78,
  parameter int         Y_START       = 58,
  parameter logic [2:0] SPRITE_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR     = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       game_clk,
  input  logic [1:0] dir,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       hit_wall,
  output logic       overrun
);
  state_t     state;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic [2:0] cx, cy;
  logic       done, scanning, can_move, accept;
  assign scanning = is_scan(state);
  assign accept   = state == IDLE && game_clk && enable;
  box_scanner #(.SIZE(SIZE)) u_scan (
    .clk  (clk),
    .reset(reset),
    .start(accept || state == UPDATE),
    .step (scanning),
    .cx   (cx),
    .cy   (cy),
    .done (done)
  );
  // Widened sums keep the bound compares free of wrap-around.
  always_comb begin
    can_move = dir == DIR_RIGHT ? ({1'b0, pos_x} + 9'(SIZE) < 9'(X_MAX)) :
               dir == DIR_LEFT  ? pos_x != 8'd0 :
               dir == DIR_DOWN  ? ({1'b0, pos_y} + 8'(SIZE) < 8'(Y_MAX)) :
                                  pos_y != 7'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT_DRAW;
      pos_x   <= 8'(X_START);
      pos_y   <= 7'(Y_START);
      overrun <= 1'b0;
    end else begin
      overrun <= game_clk && state != IDLE;
      case (state)
        INIT_DRAW: if (done) state <= IDLE;
        IDLE:      if (accept) state <= ERASE;
        ERASE:     if (done) state <= UPDATE;
        UPDATE: begin
          state <= DRAW;
          if (can_move) begin
            pos_x <= dir == DIR_RIGHT ? pos_x + 8'd1 : dir == DIR_LEFT ? pos_x - 8'd1 : pos_x;
            pos_y <= dir == DIR_DOWN ? pos_y + 7'd1 : dir == DIR_UP ? pos_y - 7'd1 : pos_y;
          end
        end
        DRAW:      if (done) state <= IDLE;
        default:   state <= INIT_DRAW;
      endcase
    end
  end
  assign busy       = state != IDLE;
  assign plot       = ~reset & scanning;
  assign hit_wall   = state == UPDATE && !can_move;
  assign vga_x      = pos_x + 8'(cx);
  assign vga_y      = pos_y + 7'(cy);
  assign vga_colour = state == ERASE ? BG_COLOUR : SPRITE_COLOUR;
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: scoreboard bench; expected pixel writes are queued per move and popped on each plot.
module tb_sprite_mover;
  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, game_clk = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, hit_wall, overrun;

  sprite_mover dut (
    .clk(clk), .reset(reset), .enable(enable), .game_clk(game_clk), .dir(dir),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .hit_wall(hit_wall), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  pix_t q[$];
  pix_t e;
  int checks = 0, failures = 0, hw_cnt = 0, ov_cnt = 0;
  int mx = 78, my = 58;

  always @(negedge clk) begin
    if (hit_wall) hw_cnt++;
    if (overrun) ov_cnt++;
    if (plot) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d expected no write", vga_x, vga_y, vga_colour);
      end else begin
        e = q.pop_front();
        if ({vga_x, vga_y, vga_colour} !== e) begin
          failures++;
          $display("FAIL pixel got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                   vga_x, vga_y, vga_colour, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic push_box(input int x, input int y, input logic [2:0] c);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) q.push_back({8'(x + i), 7'(y + j), c});
  endtask

  task automatic model_move(input logic [1:0] d, output logic hit);
    int nx, ny;
    nx = mx;
    ny = my;
    case (d)
      2'd0: if (mx + 4 < 160) nx = mx + 1;
      2'd1: if (mx > 0) nx = mx - 1;
      2'd2: if (my + 4 < 120) ny = my + 1;
      default: if (my > 0) ny = my - 1;
    endcase
    hit = nx == mx && ny == my;
    push_box(mx, my, 3'b000);
    mx = nx;
    my = ny;
    push_box(mx, my, 3'b111);
  endtask

  task automatic tick(input logic [1:0] d);
    logic exp_hit;
    model_move(d, exp_hit);
    dir = d;
    enable = 1'b1;
    game_clk = 1'b1;
    cyc(1);
    game_clk = 1'b0;
    cyc(16);
    mid();
    checks++;
    if (hit_wall !== exp_hit) begin
      failures++;
      $display("FAIL hit_wall_update got %b expected %b (pos %0d,%0d)", hit_wall, exp_hit, mx, my);
    end
    checks++;
    if (plot !== 1'b0) begin failures++; $display("FAIL plot_update got %b expected 0", plot); end
    cyc(16);
    mid();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_last_draw got %b expected 1", busy); end
    cyc(1);
    mid();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_idle got %b expected 0", busy); end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL missing_writes got %0d left expected 0", q.size()); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    mid();
    checks += 7;
    if (plot !== 1'b0) begin failures++; $display("FAIL rst_plot got %b expected 0", plot); end
    if (hit_wall !== 1'b0) begin failures++; $display("FAIL rst_hit_wall got %b expected 0", hit_wall); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got %b expected 0", overrun); end
    if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got %b expected 1", busy); end
    if (vga_x !== 8'd78) begin failures++; $display("FAIL rst_vga_x got %0d expected 78", vga_x); end
    if (vga_y !== 7'd58) begin failures++; $display("FAIL rst_vga_y got %0d expected 58", vga_y); end
    if (vga_colour !== 3'b111) begin failures++; $display("FAIL rst_colour got %b expected 111", vga_colour); end
    push_box(78, 58, 3'b111);
    cyc(1);
    reset = 1'b0;
    cyc(15);
    mid();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL init_busy got %b expected 1", busy); end
    cyc(1);
    mid();
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL init_done_busy got %b expected 0", busy); end
    if (q.size() != 0) begin failures++; $display("FAIL init_writes got %0d left expected 0", q.size()); end
  endtask

  task automatic test_first_move();
    tick(2'd0);
  endtask

  task automatic test_right_wall();
    int h0;
    while (mx < 156) tick(2'd0);
    h0 = hw_cnt;
    tick(2'd0);
    checks++;
    if (hw_cnt !== h0 + 1) begin failures++; $display("FAIL right_wall_pulses got %0d expected %0d", hw_cnt - h0, 1); end
  endtask

  task automatic test_top_wall();
    int h0;
    while (my > 0) tick(2'd3);
    h0 = hw_cnt;
    tick(2'd3);
    tick(2'd2);
    tick(2'd1);
    checks++;
    if (hw_cnt !== h0 + 1) begin failures++; $display("FAIL top_wall_pulses got %0d expected %0d", hw_cnt - h0, 1); end
  endtask

  task automatic test_overrun();
    int ov0;
    logic h;
    ov0 = ov_cnt;
    model_move(2'd2, h);
    dir = 2'd2;
    enable = 1'b1;
    game_clk = 1'b1;
    cyc(1);
    game_clk = 1'b0;
    cyc(4);
    game_clk = 1'b1;
    cyc(1);
    game_clk = 1'b0;
    mid();
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_pulse got %b expected 1", overrun); end
    cyc(28);
    mid();
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL overrun_idle got %b expected 0", busy); end
    if (q.size() != 0) begin failures++; $display("FAIL overrun_writes got %0d left expected 0", q.size()); end
    if (ov_cnt !== ov0 + 1) begin failures++; $display("FAIL overrun_count got %0d expected 1", ov_cnt - ov0); end
  endtask

  task automatic test_reset_mid_draw();
    logic h;
    model_move(2'd0, h);
    dir = 2'd0;
    enable = 1'b1;
    game_clk = 1'b1;
    cyc(1);
    game_clk = 1'b0;
    cyc(24);
    reset = 1'b1;
    mid();
    checks++;
    if (plot !== 1'b0) begin failures++; $display("FAIL reset_mid_plot got %b expected 0", plot); end
    q.delete();
    mx = 78;
    my = 58;
    push_box(78, 58, 3'b111);
    cyc(1);
    reset = 1'b0;
    cyc(16);
    mid();
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL restart_busy got %b expected 0", busy); end
    if (q.size() != 0) begin failures++; $display("FAIL restart_writes got %0d left expected 0", q.size()); end
  endtask

  task automatic test_enable_low();
    int ov0;
    ov0 = ov_cnt;
    enable = 1'b0;
    game_clk = 1'b1;
    cyc(1);
    game_clk = 1'b0;
    cyc(4);
    mid();
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL disabled_busy got %b expected 0", busy); end
    if (ov_cnt !== ov0) begin failures++; $display("FAIL disabled_overrun got %0d expected 0", ov_cnt - ov0); end
    tick(2'd0);
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_right_wall();
    test_top_wall();
    test_overrun();
    test_reset_mid_draw();
    test_enable_low();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish expected finish within bound");
    $fatal(1);
  end
endmodule
